// File: rtl/voting_pkg.sv
// Shared types and default sizing for the plurality voting ballot sequencer.
package voting_pkg;

  localparam int unsigned DEF_N_VOTERS = 4;
  localparam int unsigned DEF_CAND_W   = 2;
  localparam int unsigned DEF_M        = 2 ** DEF_CAND_W;
  localparam int unsigned DEF_VID_W    = $clog2(DEF_N_VOTERS);
  localparam int unsigned DEF_CNT_W    = $clog2(DEF_N_VOTERS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    TALLY   = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_VID_W-1:0]  voter_id;
    logic [DEF_CAND_W-1:0] choice;
  } ballot_t;

endpackage

// File: rtl/voting_tally_bank.sv
// Per-candidate vote counters: synchronous clear, increment by choice, indexed read.
module voting_tally_bank #(
  parameter int unsigned CAND_W = 2,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [CAND_W-1:0] inc_sel_i,
  input  logic [CAND_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0]  rd_cnt_o
);

  localparam int unsigned M = 2 ** CAND_W;

  logic [CNT_W-1:0] tally_q [M];
  logic [CNT_W-1:0] tally_d [M];

  always_comb begin
    for (int c = 0; c < int'(M); c++) begin
      tally_d[c] = tally_q[c];
      if (clr_i) begin
        tally_d[c] = '0;
      end else if (inc_i && (inc_sel_i == CAND_W'(c))) begin
        tally_d[c] = tally_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(M); c++) tally_q[c] <= '0;
    end else begin
      for (int c = 0; c < int'(M); c++) tally_q[c] <= tally_d[c];
    end
  end

  assign rd_cnt_o = tally_q[rd_idx_i];

endmodule

// File: rtl/voting_ballot_sequencer.sv
// Election round controller: ballot intake with duplicate/range rejection,
// sequential argmax scan over the tally bank, and a held result port.
module voting_ballot_sequencer
  import voting_pkg::*;
#(
  parameter int unsigned N_VOTERS = DEF_N_VOTERS,
  parameter int unsigned CAND_W   = DEF_CAND_W,
  parameter int unsigned VID_W    = DEF_VID_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              close,
  input  logic              ballot_valid,
  output logic              ballot_ready,
  input  logic [VID_W-1:0]  ballot_voter_id,
  input  logic [CAND_W-1:0] ballot_choice,
  output logic              ballot_err,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CAND_W-1:0] result_winner,
  output logic [CNT_W-1:0]  result_count,
  output logic [CNT_W-1:0]  result_turnout
);

  localparam int unsigned M = 2 ** CAND_W;

  state_e              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CNT_W-1:0]    turnout_q, turnout_d;
  logic [CAND_W-1:0]   idx_q, idx_d;
  logic [CAND_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [CAND_W-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    rturn_q, rturn_d;
  logic                err_q, err_d;
  logic                ready_q, busy_q, rvalid_q;
  logic                tally_clr, tally_inc;
  logic                in_range, already;
  logic [CNT_W-1:0]    rd_cnt;

  voting_tally_bank #(
    .CAND_W (CAND_W),
    .CNT_W  (CNT_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tally_clr),
    .inc_i     (tally_inc),
    .inc_sel_i (ballot_choice),
    .rd_idx_i  (idx_q),
    .rd_cnt_o  (rd_cnt)
  );

  // Voter lookup is range-guarded so an out-of-range id never indexes the bitmap.
  always_comb begin
    in_range = 32'(ballot_voter_id) < N_VOTERS;
    already  = 1'b0;
    for (int v = 0; v < int'(N_VOTERS); v++) begin
      if (ballot_voter_id == VID_W'(v)) already = voted_q[v];
    end
  end

  always_comb begin
    state_d    = state_q;
    voted_d    = voted_q;
    turnout_d  = turnout_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    winner_d   = winner_q;
    count_d    = count_q;
    rturn_d    = rturn_q;
    err_d      = 1'b0;
    tally_clr  = 1'b0;
    tally_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          voted_d   = '0;
          turnout_d = '0;
          tally_clr = 1'b1;
        end
      end
      COLLECT: begin
        if (ballot_valid) begin
          if (!in_range || already) begin
            err_d = 1'b1;
          end else begin
            tally_inc = 1'b1;
            turnout_d = turnout_q + CNT_W'(1);
            for (int v = 0; v < int'(N_VOTERS); v++) begin
              if (ballot_voter_id == VID_W'(v)) voted_d[v] = 1'b1;
            end
          end
        end
        if (close || (tally_inc && (&voted_d))) begin
          state_d    = TALLY;
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end
      end
      TALLY: begin
        if (rd_cnt > best_cnt_q) begin
          best_idx_d = idx_q;
          best_cnt_d = rd_cnt;
        end
        if (idx_q == CAND_W'(M - 1)) begin
          state_d  = DONE;
          winner_d = best_idx_d;
          count_d  = best_cnt_d;
          rturn_d  = turnout_q;
        end else begin
          idx_d = idx_q + CAND_W'(1);
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      voted_q    <= '0;
      turnout_q  <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      winner_q   <= '0;
      count_q    <= '0;
      rturn_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      voted_q    <= voted_d;
      turnout_q  <= turnout_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      winner_q   <= winner_d;
      count_q    <= count_d;
      rturn_q    <= rturn_d;
      err_q      <= err_d;
      ready_q    <= (state_d == COLLECT);
      busy_q     <= (state_d != IDLE);
      rvalid_q   <= (state_d == DONE);
    end
  end

  assign ballot_ready   = ready_q;
  assign ballot_err     = err_q;
  assign busy           = busy_q;
  assign result_valid   = rvalid_q;
  assign result_winner  = winner_q;
  assign result_count   = count_q;
  assign result_turnout = rturn_q;

endmodule

// File: tb/tb_voting_ballot_sequencer.sv
// Directed plus randomized rounds against a set-and-count election model.
module tb_voting_ballot_sequencer;

  localparam int unsigned NV   = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned VW   = 3;
  localparam int unsigned NW   = 3;
  localparam int unsigned NCND = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, close = 1'b0;
  logic          ballot_valid = 1'b0;
  logic          ballot_ready, ballot_err, busy, result_valid;
  logic          result_ready = 1'b0;
  logic [VW-1:0] ballot_voter_id = '0;
  logic [CW-1:0] ballot_choice = '0;
  logic [CW-1:0] result_winner;
  logic [NW-1:0] result_count, result_turnout;

  int n_assert = 0;
  int n_fail   = 0;

  int mdl_tally [NCND];
  bit mdl_voted [NV];
  int mdl_turn;

  always #5 clk = ~clk;

  voting_ballot_sequencer #(
    .N_VOTERS (NV),
    .CAND_W   (CW),
    .VID_W    (VW),
    .CNT_W    (NW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .close           (close),
    .ballot_valid    (ballot_valid),
    .ballot_ready    (ballot_ready),
    .ballot_voter_id (ballot_voter_id),
    .ballot_choice   (ballot_choice),
    .ballot_err      (ballot_err),
    .busy            (busy),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_winner   (result_winner),
    .result_count    (result_count),
    .result_turnout  (result_turnout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mdl_full();
    for (int v = 0; v < int'(NV); v++) if (!mdl_voted[v]) return 1'b0;
    return 1'b1;
  endfunction

  // Winner: highest count, lowest index among those holding it.
  function automatic int mdl_max();
    int mx = 0;
    for (int c = 0; c < int'(NCND); c++) if (mdl_tally[c] > mx) mx = mdl_tally[c];
    return mx;
  endfunction

  function automatic int mdl_winner();
    int mx = mdl_max();
    for (int c = 0; c < int'(NCND); c++) if (mdl_tally[c] == mx) return c;
    return 0;
  endfunction

  task automatic open_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < int'(NCND); c++) mdl_tally[c] = 0;
    for (int v = 0; v < int'(NV); v++) mdl_voted[v] = 1'b0;
    mdl_turn = 0;
    chk("open_ready", int'(ballot_ready), 1);
    chk("open_busy", int'(busy), 1);
  endtask

  task automatic send(input int id, input int ch, input bit with_close);
    bit rej;
    rej = (id >= int'(NV)) || mdl_voted[id];
    ballot_valid    = 1'b1;
    ballot_voter_id = VW'(id);
    ballot_choice   = CW'(ch);
    close           = with_close;
    tick();
    ballot_valid = 1'b0;
    close        = 1'b0;
    if (!rej) begin
      mdl_voted[id] = 1'b1;
      mdl_tally[ch]++;
      mdl_turn++;
    end
    chk("ballot_err", int'(ballot_err), int'(rej));
  endtask

  task automatic do_close();
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  // Called right after the cycle that ended collection.
  task automatic wait_result(input string tag);
    int n = 0;
    chk({tag, "_tally_ready"}, int'(ballot_ready), 0);
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, int'(NCND));
    chk({tag, "_winner"}, int'(result_winner), mdl_winner());
    chk({tag, "_count"}, int'(result_count), mdl_max());
    chk({tag, "_turnout"}, int'(result_turnout), mdl_turn);
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("take_valid", int'(result_valid), 0);
    chk("take_busy", int'(busy), 0);
  endtask

  initial begin
    #12;
    chk("rst_ready", int'(ballot_ready), 0);
    chk("rst_err", int'(ballot_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_winner", int'(result_winner), 0);
    chk("rst_count", int'(result_count), 0);
    chk("rst_turnout", int'(result_turnout), 0);
    rst = 1'b0;
    tick();

    // Basic round
    open_round();
    send(0, 2, 1'b0); send(1, 2, 1'b0); send(2, 1, 1'b0); send(3, 3, 1'b0);
    wait_result("basic");
    take_result();

    // Tie-break toward lowest index
    open_round();
    send(0, 3, 1'b0); send(1, 1, 1'b0); send(2, 3, 1'b0); send(3, 1, 1'b0);
    wait_result("tie");
    take_result();

    // Duplicate and out-of-range rejection
    open_round();
    send(1, 0, 1'b0); send(1, 2, 1'b0); send(5, 2, 1'b0);
    chk("dup_still_collect", int'(ballot_ready), 1);
    send(0, 2, 1'b0); send(2, 2, 1'b0);
    chk("dup_not_full", int'(ballot_ready), 1);
    send(3, 0, 1'b0);
    wait_result("dup");

    // Backpressure: result held, start ignored
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      tick();
      chk("bp_valid", int'(result_valid), 1);
      chk("bp_ready", int'(ballot_ready), 0);
      chk("bp_winner", int'(result_winner), mdl_winner());
      chk("bp_count", int'(result_count), mdl_max());
      chk("bp_turnout", int'(result_turnout), mdl_turn);
    end
    start = 1'b0;
    take_result();
    chk("idle_keeps_winner", int'(result_winner), mdl_winner());

    // Early close, and close together with a final ballot
    open_round();
    send(0, 0, 1'b0); send(3, 0, 1'b0);
    do_close();
    wait_result("early");
    take_result();

    open_round();
    do_close();
    wait_result("empty");
    take_result();

    open_round();
    send(2, 3, 1'b0); send(0, 1, 1'b1);
    wait_result("close_with_ballot");
    take_result();

    // Async reset between edges mid-TALLY
    open_round();
    send(1, 2, 1'b0); send(2, 2, 1'b0);
    do_close();
    tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(result_valid), 0);
    chk("arst_ready", int'(ballot_ready), 0);
    chk("arst_winner", int'(result_winner), 0);
    #1 rst = 1'b0;
    tick();
    open_round();
    send(0, 3, 1'b0);
    do_close();
    wait_result("post_rst");
    take_result();

    // Randomized rounds
    for (int r = 0; r < 12; r++) begin
      int nb;
      open_round();
      nb = int'($urandom_range(0, 9));
      for (int b = 0; b < nb && !mdl_full(); b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0);
      end
      if (!mdl_full()) begin
        if ($urandom_range(0, 1) == 1) send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
        else do_close();
      end
      wait_result("rand");
      repeat ($urandom_range(0, 3)) tick();
      take_result();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
